booth_product_accumulator: RTL and testbench
============================================

BOOTH_PRODUCT_ACCUMULATOR -- requirements
Module: booth_product_accumulator

Interface
REQ-001 The block SHALL have parameter PROD_W, default 8: width of the signed product from the 4-bit Booth multiplier stage.
REQ-002 The block SHALL have parameter ACC_W, default 16: width of the signed accumulator, with ACC_W > PROD_W.
REQ-003 The block SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1: begins a new accumulation; sampled in IDLE only.
REQ-006 The block SHALL have port len, input, 4: number of products to accumulate, sampled with start; value 0 means 16.
REQ-007 The block SHALL have port prod, input, PROD_W: signed product from the multiplier.
REQ-008 The block SHALL have port prod_valid, input, 1: prod is valid.
REQ-009 The block SHALL have port prod_ready, output, 1: block accepts prod this cycle.
REQ-010 The block SHALL have port acc_out, output, ACC_W: signed accumulated result.
REQ-011 The block SHALL have port acc_valid, output, 1: acc_out is valid.
REQ-012 The block SHALL have port acc_ready, input, 1: consumer accepts acc_out.
REQ-013 The block SHALL have port ovf, output, 1: signed overflow occurred in the current or last accumulation.
REQ-014 The block SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-015 The block SHALL implement FSM states IDLE, ACCUM and DONE.
REQ-016 In IDLE with start=1, the block SHALL clear acc and ovf, load count (len, or 16 if len=0) and enter ACCUM next cycle.
REQ-017 In ACCUM, prod_ready SHALL be 1; prod_ready SHALL be 0 in IDLE and DONE.
REQ-018 A product SHALL be accepted only on a cycle with prod_valid=1 and prod_ready=1; that cycle, acc SHALL add sign-extended prod and count SHALL decrement by 1.
REQ-019 Cycles with prod_valid=0 in ACCUM SHALL leave acc and count unchanged.
REQ-020 Acceptance of the last product (count=1) SHALL move the FSM to DONE, with acc_valid=1 on the next cycle (latency 1 cycle).
REQ-021 In DONE, acc_out SHALL be held stable while acc_ready=0; acc_valid=1 with acc_ready=1 SHALL return the FSM to IDLE with acc_valid=0 on the next cycle.
REQ-022 start SHALL be ignored outside IDLE.
REQ-023 acc_out SHALL present the accumulator register at all times; ovf SHALL remain valid until the next start.
REQ-024 Signed overflow of an addition SHALL set ovf sticky; overflow is detected when both operands have equal sign and the sum sign differs.

Reset
REQ-025 rst_n=0 SHALL asynchronously force IDLE, with acc_out=0, count=0, acc_valid=0, prod_ready=0, ovf=0 and busy=0, including mid-ACCUM or mid-DONE; any partial result SHALL be discarded.
REQ-026 After reset release, the block SHALL take no action until start.

Configuration
REQ-027 With macro BOOTH_ACC_SATURATE_EN defined, an overflowing addition SHALL clamp acc to +(2^(ACC_W-1)-1) or -(2^(ACC_W-1)) by the direction of the overflow and SHALL set ovf.
REQ-028 Without BOOTH_ACC_SATURATE_EN, acc SHALL wrap modulo 2^ACC_W and ovf SHALL still set.

Verification
REQ-029 Directed test: len=4, products 3,-2,5,7 with continuous valid -> acc_out=13, ovf=0, acc_valid 1 cycle after 4th handshake.
REQ-030 Directed test: len=0, 16 products of -128 -> acc_out=-2048, ovf=0, exactly 16 handshakes then prod_ready=0.
REQ-031 Directed test with ACC_W=10: len=5, products 127 x5 -> wrap build acc_out=-389, ovf=1; with BOOTH_ACC_SATURATE_EN acc_out=511, ovf=1.
REQ-032 Directed test: prod_valid toggling 1,0,0,1,0,1 with len=3, products 10,20,30 -> acc_out=60; idle cycles do not count.
REQ-033 Directed test: in DONE, hold acc_ready=0 for 3 cycles, then 1 -> acc_out stable and acc_valid=1 throughout, IDLE next cycle; start pulsed during DONE is ignored.
REQ-034 Directed test: assert rst_n=0 after 2 of 4 products -> all outputs 0 immediately; a new start with len=1, product -5 -> acc_out=-5.

Source files
------------

// File: rtl/booth_product_accumulator.sv
// Accumulates len signed Booth products with a sticky signed-overflow flag.
// Define BOOTH_ACC_SATURATE_EN to clamp on overflow instead of wrapping.
module booth_product_accumulator #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        len,
  input  logic [PROD_W-1:0] prod,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic              ovf,
  output logic              busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [ACC_W-1:0] ACC_MAX =
    {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN =
    {1'b1, {(ACC_W-1){1'b0}}};

  logic [1:0]       state;
  logic [4:0]       count;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] nxt;
  logic             add_ovf;
  logic             take;

  assign take = prod_valid && prod_ready;
  assign ext  = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign sum  = acc + ext;

  assign add_ovf = (acc[ACC_W-1] == ext[ACC_W-1])
                && (sum[ACC_W-1] != acc[ACC_W-1]);

`ifdef BOOTH_ACC_SATURATE_EN
  assign nxt = !add_ovf       ? sum     :
               acc[ACC_W-1]   ? ACC_MIN : ACC_MAX;
`else
  assign nxt = sum;
`endif

  assign prod_ready = (state == ACCUM);
  assign acc_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  assign acc_out    = acc;

  // Control FSM, accumulator, remaining count and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= 5'd0;
      acc   <= '0;
      ovf   <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (start) begin
            acc   <= '0;
            ovf   <= 1'b0;
            count <= (len == 4'd0) ? 5'd16 : {1'b0, len};
            state <= ACCUM;
          end
        end
        (state == ACCUM): begin
          if (take) begin
            acc   <= nxt;
            count <= count - 5'd1;
            if (add_ovf)
              ovf <= 1'b1;
            if (count == 5'd1)
              state <= DONE;
          end
        end
        (state == DONE): begin
          if (acc_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Bench for booth_product_accumulator at ACC_W=16 and ACC_W=10.
// A behavioural model is checked every cycle plus literal expectations.
module tb_booth_product_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] len = 4'd0;
  logic [7:0] prod = 8'd0;
  logic       prod_valid = 1'b0;
  logic       acc_ready = 1'b0;

  logic        pr16, av16, ov16, bz16;
  logic [15:0] acc16;
  logic        pr10, av10, ov10, bz10;
  logic [9:0]  acc10;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;

  always #5 clk = ~clk;

  booth_product_accumulator #(.PROD_W(8), .ACC_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .prod(prod), .prod_valid(prod_valid), .prod_ready(pr16),
    .acc_out(acc16), .acc_valid(av16), .acc_ready(acc_ready),
    .ovf(ov16), .busy(bz16)
  );

  booth_product_accumulator #(.PROD_W(8), .ACC_W(10)) dut10 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .prod(prod), .prod_valid(prod_valid), .prod_ready(pr10),
    .acc_out(acc10), .acc_valid(av10), .acc_ready(acc_ready),
    .ovf(ov10), .busy(bz10)
  );

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 collecting products, 2 result waiting
  int     m_phase = 0;
  int     m_left  = 0;
  longint m_acc [2] = '{0, 0};
  bit     m_ovf [2] = '{0, 0};

  function automatic int width_of(input int k);
    return (k == 0) ? 16 : 10;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_left  = 0;
      m_acc   = '{0, 0};
      m_ovf   = '{0, 0};
    end else begin
      if (m_phase == 0) begin
        if (start) begin
          m_acc   = '{0, 0};
          m_ovf   = '{0, 0};
          m_left  = (len == 0) ? 16 : int'(len);
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (prod_valid) begin
          for (int k = 0; k < 2; k++) begin
            longint lim;
            longint s;
            lim = longint'(1) << (width_of(k) - 1);
            s   = m_acc[k] + longint'($signed(prod));
            if (s > lim - 1 || s < -lim) begin
              m_ovf[k] = 1'b1;
`ifdef BOOTH_ACC_SATURATE_EN
              s = (s > 0) ? lim - 1 : -lim;
`else
              s = (s > 0) ? s - 2 * lim : s + 2 * lim;
`endif
            end
            m_acc[k] = s;
          end
          m_left = m_left - 1;
          if (m_left == 0)
            m_phase = 2;
        end
      end else begin
        if (acc_ready)
          m_phase = 0;
      end
    end
  end

  always @(posedge clk)
    if (rst_n && prod_valid && pr16)
      hs_cnt <= hs_cnt + 1;

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Per-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    chk("acc16", longint'($signed(acc16)), m_acc[0]);
    chk("acc10", longint'($signed(acc10)), m_acc[1]);
    chk("ovf16", longint'(ov16), longint'(m_ovf[0]));
    chk("ovf10", longint'(ov10), longint'(m_ovf[1]));
    chk("ready16", longint'(pr16), longint'(m_phase == 1));
    chk("ready10", longint'(pr10), longint'(m_phase == 1));
    chk("valid16", longint'(av16), longint'(m_phase == 2));
    chk("valid10", longint'(av10), longint'(m_phase == 2));
    chk("busy16", longint'(bz16), longint'(m_phase != 0));
    chk("busy10", longint'(bz10), longint'(m_phase != 0));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic begin_acc(input logic [3:0] l);
    int t;
    t = 0;
    while (bz16 && t < 50) begin
      tick();
      t++;
    end
    if (bz16) chk("start_timeout", 1, 0);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input int p);
    int t;
    t = 0;
    prod       = 8'(p);
    prod_valid = 1'b1;
    while (!pr16 && t < 50) begin
      tick();
      t++;
    end
    if (!pr16) chk("send_timeout", 1, 0);
    tick();
  endtask

  task automatic idle(input int n);
    prod_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic consume();
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p4 [4] = '{3, -2, 5, 7};
    logic [15:0] held;

    tick();
    tick();
    chk("rst_acc", longint'(acc16), 0);
    chk("rst_busy", longint'(bz16), 0);
    rst_n = 1'b1;
    idle(3);
    chk("post_rst_idle", longint'(bz16), 0);

    // len=4: 3,-2,5,7 continuous
    begin_acc(4'd4);
    foreach (p4[i]) send(p4[i]);
    prod_valid = 1'b0;
    chk("sum13_valid", longint'(av16), 1);
    chk("sum13", longint'($signed(acc16)), 13);
    chk("sum13_ovf", longint'(ov16), 0);
    consume();

    // len=0 means 16 products of -128
    hs_cnt = 0;
    begin_acc(4'd0);
    for (int i = 0; i < 16; i++) send(-128);
    chk("n16_ready_low", longint'(pr16), 0);
    tick();
    prod_valid = 1'b0;
    chk("n16_handshakes", longint'(hs_cnt), 16);
    chk("n16_sum", longint'($signed(acc16)), -2048);
    chk("n16_ovf", longint'(ov16), 0);
    consume();

    // 127 x5: fits 16 bits, overflows 10 bits
    begin_acc(4'd5);
    for (int i = 0; i < 5; i++) send(127);
    prod_valid = 1'b0;
    chk("p635_w16", longint'($signed(acc16)), 635);
`ifdef BOOTH_ACC_SATURATE_EN
    chk("p635_w10", longint'($signed(acc10)), 511);
`else
    chk("p635_w10", longint'($signed(acc10)), -389);
`endif
    chk("p635_ovf10", longint'(ov10), 1);
    chk("p635_ovf16", longint'(ov16), 0);
    consume();

    // valid pattern 1,0,0,1,0,1
    begin_acc(4'd3);
    send(10);
    idle(2);
    send(20);
    idle(1);
    send(30);
    prod_valid = 1'b0;
    chk("gap_sum", longint'($signed(acc16)), 60);
    chk("gap_valid", longint'(av16), 1);

    // hold result 3 cycles, pulse start meanwhile
    held = acc16;
    for (int i = 0; i < 3; i++) begin
      start = (i == 1);
      len   = 4'd2;
      tick();
      chk("hold_acc", longint'(acc16), longint'(held));
      chk("hold_valid", longint'(av16), 1);
    end
    start = 1'b0;
    consume();
    chk("rel_valid", longint'(av16), 0);
    chk("rel_busy", longint'(bz16), 0);
    tick();
    chk("start_ignored", longint'(bz16), 0);

    // reset after 2 of 4 products
    begin_acc(4'd4);
    send(9);
    send(4);
    prod_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_acc", longint'(acc16), 0);
    chk("mid_rst_ready", longint'(pr16), 0);
    chk("mid_rst_busy", longint'(bz16), 0);
    chk("mid_rst_valid", longint'(av16), 0);
    chk("mid_rst_ovf", longint'(ov16), 0);
    tick();
    rst_n = 1'b1;
    tick();
    begin_acc(4'd1);
    send(-5);
    prod_valid = 1'b0;
    chk("after_rst_sum", longint'($signed(acc16)), -5);
    chk("after_rst_valid", longint'(av16), 1);
    consume();
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
